// File: rtl/receive.sv
// Instruction loader: requests a burst from transmit, stores acked words in a
// local buffer, reports count/status, and serves a registered fetch read port.
module receive #(
  parameter int IWIDTH  = 32,
  parameter int AWIDTH  = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_start,
  output logic              r_o_syn,
  input  logic [IWIDTH-1:0] r_i_instr,
  input  logic              r_i_last,
  input  logic              r_i_ack,
  input  logic [AWIDTH-1:0] r_i_raddr,
  output logic [IWIDTH-1:0] r_o_rdata,
  output logic [AWIDTH:0]   r_o_count,
  output logic              r_o_busy,
  output logic              r_o_done,
  output logic              r_o_overflow,
  output logic              r_o_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t            state, state_n;
  logic [AWIDTH:0]   count_n;
  logic              ovf_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              wr_en;
  logic [IWIDTH-1:0] mem [DEPTH];

  always_comb begin
    state_n = state;
    count_n = r_o_count;
    ovf_n   = r_o_overflow;
    tcnt_n  = tcnt;
    wr_en   = 1'b0;
    case (state)
      LOAD: begin
        if (r_i_ack) begin
          tcnt_n = '0;
          if (r_o_count < (AWIDTH+1)'(DEPTH)) begin
            wr_en   = 1'b1;
            count_n = r_o_count + (AWIDTH+1)'(1);
          end else begin
            ovf_n = 1'b1;
          end
          if (r_i_last) state_n = DONE;
        end else if (TIMEOUT != 0) begin
          tcnt_n = tcnt + TW'(1);
          if (tcnt_n == TW'(TIMEOUT)) state_n = ERR;
        end
      end
      default: begin
        if (r_i_start) begin
          state_n = LOAD;
          count_n = '0;
          ovf_n   = 1'b0;
          tcnt_n  = '0;
        end
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state        <= IDLE;
      r_o_count    <= '0;
      r_o_overflow <= 1'b0;
      tcnt         <= '0;
      r_o_syn      <= 1'b0;
      r_o_busy     <= 1'b0;
      r_o_done     <= 1'b0;
      r_o_err      <= 1'b0;
      r_o_rdata    <= '0;
    end else begin
      state        <= state_n;
      r_o_count    <= count_n;
      r_o_overflow <= ovf_n;
      tcnt         <= tcnt_n;
      r_o_syn      <= (state_n == LOAD);
      r_o_busy     <= (state_n == LOAD);
      r_o_done     <= (state_n == DONE);
      r_o_err      <= (state_n == ERR);
      r_o_rdata    <= mem[r_i_raddr];
    end
  end

  // Buffer keeps its contents across reset; same-address read sees old data.
  always_ff @(posedge r_clk) begin
    if (!r_rst && wr_en) mem[r_o_count[AWIDTH-1:0]] <= r_i_instr;
  end

endmodule
